// File: rtl/time_set_if.sv
// Front-panel bus between the key debouncer / time counter and the
// time-setting controller. The controller uses the slave modport.
interface time_set_if;
  logic       key_mode;
  logic       key_next;
  logic       key_inc;
  logic       tick_1s;
  logic [3:0] cur_hour_shi, cur_hour_ge, cur_min_shi, cur_min_ge, cur_sec_shi, cur_sec_ge;
  logic       set_time_finish;
  logic [3:0] set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge;
  logic       clock_en;
  logic [3:0] clock_hour_shi, clock_hour_ge, clock_min_shi, clock_min_ge;
  logic [2:0] field_sel;
  logic       in_alarm_edit;

  modport slave (
    input  key_mode, key_next, key_inc, tick_1s,
    input  cur_hour_shi, cur_hour_ge, cur_min_shi, cur_min_ge, cur_sec_shi, cur_sec_ge,
    output set_time_finish,
    output set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge,
    output clock_en, clock_hour_shi, clock_hour_ge, clock_min_shi, clock_min_ge,
    output field_sel, in_alarm_edit
  );

  modport master (
    output key_mode, key_next, key_inc, tick_1s,
    output cur_hour_shi, cur_hour_ge, cur_min_shi, cur_min_ge, cur_sec_shi, cur_sec_ge,
    input  set_time_finish,
    input  set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge,
    input  clock_en, clock_hour_shi, clock_hour_ge, clock_min_shi, clock_min_ge,
    input  field_sel, in_alarm_edit
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-of-day / alarm setting controller. Three key pulses drive a mode
// FSM that edits BCD time and alarm fields; set_time_finish low makes the
// counter load the edited time. Edit states time out back to RUN.
module time_set_ctrl #(
  parameter int TIMEOUT_S = 10
) (
  input logic        clk,
  input logic        rst,
  time_set_if.slave  bus
);

  typedef enum logic [2:0] {RUN, T_HOUR, T_MIN, T_SEC, A_HOUR, A_MIN} state_t;

  state_t     state, state_nxt;
  logic [7:0] tcnt;
  logic [7:0] set_hour, set_min, set_sec;
  logic [7:0] alm_hour, alm_min;
  logic       alm_en;
  logic [2:0] field_sel_r;
  logic       finish_r;
  logic       alarm_edit_r;
  logic       any_key, do_next, do_inc, timeout_hit;

  // Hour increment: 23 wraps to 00 before the ge==9 carry rule applies.
  function automatic logic [7:0] bcd_inc_hour(input logic [7:0] v);
    if (v == 8'h23)       return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                  return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Minute/second increment: 59 wraps to 00.
  function automatic logic [7:0] bcd_inc_60(input logic [7:0] v);
    if (v == 8'h59)       return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                  return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Strict key priority: mode beats next beats inc.
  assign any_key     = bus.key_mode | bus.key_next | bus.key_inc;
  assign do_next     = bus.key_next & ~bus.key_mode;
  assign do_inc      = bus.key_inc & ~bus.key_mode & ~bus.key_next;
  assign timeout_hit = (state != RUN) && bus.tick_1s && !any_key &&
                       (tcnt == 8'(TIMEOUT_S - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Next-state decode from keys and inactivity timeout.
  always_comb begin
    state_nxt = state;
    if (timeout_hit) begin
      state_nxt = RUN;
    end else if (bus.key_mode) begin
      case (state)
        RUN:                  state_nxt = T_HOUR;
        T_HOUR, T_MIN, T_SEC: state_nxt = A_HOUR;
        default:              state_nxt = RUN;
      endcase
    end else if (do_next) begin
      case (state)
        T_HOUR:  state_nxt = T_MIN;
        T_MIN:   state_nxt = T_SEC;
        T_SEC:   state_nxt = T_HOUR;
        A_HOUR:  state_nxt = A_MIN;
        A_MIN:   state_nxt = A_HOUR;
        default: state_nxt = state;
      endcase
    end
  end

  // Inactivity counter: counts seconds in edit states, cleared by any key.
  always_ff @(posedge clk) begin
    if (rst || state == RUN || any_key || timeout_hit) tcnt <= 8'd0;
    else if (bus.tick_1s)                               tcnt <= tcnt + 8'd1;
  end

  // Time being edited: snapshot of live time on entry, then field increments.
  always_ff @(posedge clk) begin
    if (rst) begin
      set_hour <= 8'h00;
      set_min  <= 8'h00;
      set_sec  <= 8'h00;
    end else if (state == RUN && bus.key_mode) begin
      set_hour <= {bus.cur_hour_shi, bus.cur_hour_ge};
      set_min  <= {bus.cur_min_shi, bus.cur_min_ge};
      set_sec  <= {bus.cur_sec_shi, bus.cur_sec_ge};
    end else if (do_inc) begin
      case (state)
        T_HOUR:  set_hour <= bcd_inc_hour(set_hour);
        T_MIN:   set_min  <= bcd_inc_60(set_min);
        T_SEC:   set_sec  <= bcd_inc_60(set_sec);
        default: ;
      endcase
    end
  end

  // Alarm time and enable; key_inc in RUN toggles the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      alm_en   <= 1'b0;
      alm_hour <= 8'h07;
      alm_min  <= 8'h00;
    end else if (do_inc) begin
      case (state)
        RUN:     alm_en   <= ~alm_en;
        A_HOUR:  alm_hour <= bcd_inc_hour(alm_hour);
        A_MIN:   alm_min  <= bcd_inc_60(alm_min);
        default: ;
      endcase
    end
  end

  // Registered mode outputs decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      field_sel_r  <= 3'b000;
      finish_r     <= 1'b1;
      alarm_edit_r <= 1'b0;
    end else begin
      case (state_nxt)
        T_HOUR, A_HOUR: field_sel_r <= 3'b100;
        T_MIN, A_MIN:   field_sel_r <= 3'b010;
        T_SEC:          field_sel_r <= 3'b001;
        default:        field_sel_r <= 3'b000;
      endcase
      finish_r     <= !(state_nxt == T_HOUR || state_nxt == T_MIN || state_nxt == T_SEC);
      alarm_edit_r <= (state_nxt == A_HOUR || state_nxt == A_MIN);
    end
  end

  assign bus.set_time_finish = finish_r;
  assign bus.set_hour_shi    = set_hour[7:4];
  assign bus.set_hour_ge     = set_hour[3:0];
  assign bus.set_min_shi     = set_min[7:4];
  assign bus.set_min_ge      = set_min[3:0];
  assign bus.set_sec_shi     = set_sec[7:4];
  assign bus.set_sec_ge      = set_sec[3:0];
  assign bus.clock_en        = alm_en;
  assign bus.clock_hour_shi  = alm_hour[7:4];
  assign bus.clock_hour_ge   = alm_hour[3:0];
  assign bus.clock_min_shi   = alm_min[7:4];
  assign bus.clock_min_ge    = alm_min[3:0];
  assign bus.field_sel       = field_sel_r;
  assign bus.in_alarm_edit   = alarm_edit_r;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with a 3-second edit timeout.
module tb_time_set_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  time_set_if bus ();

  time_set_ctrl #(.TIMEOUT_S(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] set_time();
    return {bus.set_hour_shi, bus.set_hour_ge, bus.set_min_shi, bus.set_min_ge,
            bus.set_sec_shi, bus.set_sec_ge};
  endfunction

  function automatic logic [15:0] alarm();
    return {bus.clock_hour_shi, bus.clock_hour_ge, bus.clock_min_shi, bus.clock_min_ge};
  endfunction

  // Each pulse is driven for one full cycle; caller samples at the following negedge.
  task automatic pulse(input logic m, input logic n, input logic i, input logic t);
    @(negedge clk);
    bus.key_mode = m; bus.key_next = n; bus.key_inc = i; bus.tick_1s = t;
    @(negedge clk);
    bus.key_mode = 1'b0; bus.key_next = 1'b0; bus.key_inc = 1'b0; bus.tick_1s = 1'b0;
  endtask

  task automatic inc_n(input int k);
    for (int j = 0; j < k; j++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sft"},   32'(bus.set_time_finish), 32'd1);
    check({tag, "_fs"},    32'(bus.field_sel),       32'd0);
    check({tag, "_en"},    32'(bus.clock_en),        32'd0);
    check({tag, "_alm"},   32'(alarm()),             32'h0700);
    check({tag, "_iae"},   32'(bus.in_alarm_edit),   32'd0);
  endtask

  initial begin
    bus.key_mode = 1'b0; bus.key_next = 1'b0; bus.key_inc = 1'b0; bus.tick_1s = 1'b0;
    {bus.cur_hour_shi, bus.cur_hour_ge, bus.cur_min_shi, bus.cur_min_ge,
     bus.cur_sec_shi, bus.cur_sec_ge} = 24'h123456;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset("rst");
    check("rst_set", 32'(set_time()), 32'h000000);

    // Idle seconds in RUN change nothing.
    for (int j = 0; j < 20; j++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check_reset("idle");

    // Enter time edit: live time captured.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("cap_set", 32'(set_time()), 32'h123456);
    check("cap_sft", 32'(bus.set_time_finish), 32'd0);
    check("cap_fs",  32'(bus.field_sel), 32'b100);

    // 12 -> 23 -> 00.
    inc_n(11);
    check("hr23", 32'(set_time()), 32'h233456);
    inc_n(1);
    check("hr_wrap", 32'(set_time()), 32'h003456);

    // Minutes: 34 -> 58 -> 59 -> 00, hour untouched.
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("tmin_fs", 32'(bus.field_sel), 32'b010);
    inc_n(24);
    check("min58", 32'(set_time()), 32'h005856);
    inc_n(1);
    check("min59", 32'(set_time()), 32'h005956);
    inc_n(1);
    check("min_wrap", 32'(set_time()), 32'h000056);

    // Seconds: 56 -> 59 -> 00.
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("tsec_fs", 32'(bus.field_sel), 32'b001);
    inc_n(3);
    check("sec59", 32'(set_time()), 32'h000059);
    inc_n(1);
    check("sec_wrap", 32'(set_time()), 32'h000000);
    check("sec_fs2", 32'(bus.field_sel), 32'b001);

    // Commit time, enter alarm edit.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("ah_sft", 32'(bus.set_time_finish), 32'd1);
    check("ah_iae", 32'(bus.in_alarm_edit), 32'd1);
    check("ah_fs",  32'(bus.field_sel), 32'b100);
    check("ah_set_hold", 32'(set_time()), 32'h000000);
    inc_n(1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("am_fs", 32'(bus.field_sel), 32'b010);
    inc_n(3);
    check("alm_0803", 32'(alarm()), 32'h0803);

    // Back to RUN; key_inc toggles enable, key_next ignored.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("run_fs",  32'(bus.field_sel), 32'b000);
    check("run_iae", 32'(bus.in_alarm_edit), 32'd0);
    inc_n(1);
    check("en_on", 32'(bus.clock_en), 32'd1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("run_next_ign", 32'(bus.field_sel), 32'b000);

    // key_mode + key_inc together: mode wins, enable untouched.
    pulse(1'b1, 1'b0, 1'b1, 1'b0);
    check("prio_fs",  32'(bus.field_sel), 32'b100);
    check("prio_en",  32'(bus.clock_en), 32'd1);
    check("prio_set", 32'(set_time()), 32'h123456);

    // Timeout: 2 ticks, key clears, then the 3rd tick returns to RUN.
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("to_2tick", 32'(bus.field_sel), 32'b100);
    inc_n(1);
    check("to_inc", 32'(set_time()), 32'h133456);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("to_2nd", 32'(bus.set_time_finish), 32'd0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("to_3rd_fs",  32'(bus.field_sel), 32'b000);
    check("to_3rd_sft", 32'(bus.set_time_finish), 32'd1);
    check("to_commit",  32'(set_time()), 32'h133456);

    // Into A_MIN, edit, then reset discards everything.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("amin_iae", 32'(bus.in_alarm_edit), 32'd1);
    inc_n(1);
    check("amin_inc", 32'(alarm()), 32'h0804);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("rst2");
    check("rst2_set", 32'(set_time()), 32'h000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
